// File: rtl/burst_write_controller.sv
// -----------------------------------------------------------------------------
// burst_write_controller
//
// Drains committed store data from the upstream burst buffer and issues it to
// external memory as one incrementing write burst per request.
//
// Flow: IDLE (accept request) -> WAIT_DATA (wait for validated, sufficient
// buffer contents) -> ADDRESS (address handshake) -> DATA (one pull per beat)
// -> RESPONSE (collect write response, pulse done/error) -> IDLE.
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   flush_i                 blocks the burst start decision in its cycle
//   req_valid_i/ready_o     burst request handshake
//   req_address_i           burst base byte address (word aligned)
//   req_length_i            beat count, 1..MAX_BURST
//   buffer_size_i           buffer occupancy
//   buffer_valid_i          all buffer entries validated
//   buffer_pull_o           pull one word; data on buffer_data_i next cycle
//   buffer_data_i           buffer read data
//   mem_aw*                 address channel (valid/ready, addr, len-1)
//   mem_w*                  data channel (valid/ready, data, last)
//   mem_b*                  response channel (valid/ready, error)
//   done_o, error_o         single-cycle completion / error pulses
// -----------------------------------------------------------------------------
module burst_write_controller #(
    parameter int BUFFER_DEPTH = 1024,
    parameter int MAX_BURST    = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            flush_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [31:0]                     req_address_i,
    input  logic [$clog2(MAX_BURST):0]      req_length_i,
    input  logic [$clog2(BUFFER_DEPTH)-1:0] buffer_size_i,
    input  logic                            buffer_valid_i,
    output logic                            buffer_pull_o,
    input  logic [31:0]                     buffer_data_i,
    output logic                            mem_awvalid_o,
    input  logic                            mem_awready_i,
    output logic [31:0]                     mem_awaddr_o,
    output logic [7:0]                      mem_awlen_o,
    output logic                            mem_wvalid_o,
    input  logic                            mem_wready_i,
    output logic [31:0]                     mem_wdata_o,
    output logic                            mem_wlast_o,
    input  logic                            mem_bvalid_i,
    output logic                            mem_bready_o,
    input  logic                            mem_berror_i,
    output logic                            done_o,
    output logic                            error_o
);

    localparam int LW = $clog2(MAX_BURST) + 1;
    localparam int SW = $clog2(BUFFER_DEPTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT     = 3'd1;
    localparam logic [2:0] S_ADDRESS  = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_RESPONSE = 3'd4;

    logic [2:0]    state_r;
    logic [2:0]    state_nx_s;
    logic [31:0]   addr_r;
    logic [LW-1:0] len_r;
    logic [LW-1:0] pulls_r;
    logic [LW-1:0] beats_r;
    logic          wvalid_r;

    logic [LW-1:0] len_m1_s;
    logic          start_s;
    logic          pull_s;
    logic          accept_s;
    logic          last_accept_s;

    assign len_m1_s = len_r - LW'(1);

    // Start decision: both operands zero-extended to 32 bits before comparing
    assign start_s = buffer_valid_i && !flush_i &&
                     ({{(32-SW){1'b0}}, buffer_size_i} >= {{(32-LW){1'b0}}, len_r});

    // A pull only happens when the output slot is empty or being drained, so
    // the word on buffer_data_i never changes under an unaccepted beat.
    assign pull_s        = (state_r == S_DATA) && (pulls_r < len_r) &&
                           (!wvalid_r || mem_wready_i);
    assign accept_s      = wvalid_r && mem_wready_i;
    assign last_accept_s = accept_s && (beats_r == len_m1_s);

    assign req_ready_o   = (state_r == S_IDLE);
    assign mem_awvalid_o = (state_r == S_ADDRESS);
    assign mem_awaddr_o  = (state_r == S_ADDRESS) ? addr_r : 32'd0;
    assign mem_awlen_o   = (state_r == S_ADDRESS) ? 8'(len_m1_s) : 8'd0;
    assign buffer_pull_o = pull_s;
    assign mem_wvalid_o  = wvalid_r;
    assign mem_wdata_o   = wvalid_r ? buffer_data_i : 32'd0;
    assign mem_wlast_o   = wvalid_r && (beats_r == len_m1_s);
    assign mem_bready_o  = (state_r == S_RESPONSE);
    // Pulses coincide with the response handshake so req_ready_o rises next cycle
    assign done_o        = (state_r == S_RESPONSE) && mem_bvalid_i;
    assign error_o       = (state_r == S_RESPONSE) && mem_bvalid_i && mem_berror_i;

    // Next-state selection for the burst sequencer
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid_i) state_nx_s = S_WAIT;
                else             state_nx_s = S_IDLE;
            end
            S_WAIT: begin
                if (start_s) state_nx_s = S_ADDRESS;
                else         state_nx_s = S_WAIT;
            end
            S_ADDRESS: begin
                if (mem_awready_i) state_nx_s = S_DATA;
                else               state_nx_s = S_ADDRESS;
            end
            S_DATA: begin
                if (last_accept_s) state_nx_s = S_RESPONSE;
                else               state_nx_s = S_DATA;
            end
            S_RESPONSE: begin
                if (mem_bvalid_i) state_nx_s = S_IDLE;
                else              state_nx_s = S_RESPONSE;
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State, request latch, beat counters and data-valid register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r  <= S_IDLE;
            addr_r   <= 32'd0;
            len_r    <= '0;
            pulls_r  <= '0;
            beats_r  <= '0;
            wvalid_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if ((state_r == S_IDLE) && req_valid_i) begin
                addr_r <= req_address_i;
                len_r  <= req_length_i;
            end
            if ((state_r == S_ADDRESS) && mem_awready_i) begin
                pulls_r <= '0;
                beats_r <= '0;
            end else begin
                if (pull_s)   pulls_r <= pulls_r + LW'(1);
                if (accept_s) beats_r <= beats_r + LW'(1);
            end
            if (pull_s)        wvalid_r <= 1'b1;
            else if (accept_s) wvalid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_burst_write_controller.sv
// -----------------------------------------------------------------------------
// tb_burst_write_controller
//
// Self-checking bench for burst_write_controller. A table of burst records
// (directed cases) is followed by randomized records; each burst is driven
// against a transaction-level model: a queue of words loaded into the buffer,
// a buffer that presents word k after the k-th pull, and the expected order of
// beats on the data channel. A reset-in-mid-burst sequence is hand-written.
// -----------------------------------------------------------------------------
module tb_burst_write_controller;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_address_i;
    logic [4:0]  req_length_i;
    logic [9:0]  buffer_size_i;
    logic        buffer_valid_i;
    logic        buffer_pull_o;
    logic [31:0] buffer_data_i;
    logic        mem_awvalid_o;
    logic        mem_awready_i;
    logic [31:0] mem_awaddr_o;
    logic [7:0]  mem_awlen_o;
    logic        mem_wvalid_o;
    logic        mem_wready_i;
    logic [31:0] mem_wdata_o;
    logic        mem_wlast_o;
    logic        mem_bvalid_i;
    logic        mem_bready_o;
    logic        mem_berror_i;
    logic        done_o;
    logic        error_o;

    int tests  = 0;
    int failed = 0;

    burst_write_controller #(.BUFFER_DEPTH(1024), .MAX_BURST(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_address_i(req_address_i), .req_length_i(req_length_i),
        .buffer_size_i(buffer_size_i), .buffer_valid_i(buffer_valid_i),
        .buffer_pull_o(buffer_pull_o), .buffer_data_i(buffer_data_i),
        .mem_awvalid_o(mem_awvalid_o), .mem_awready_i(mem_awready_i),
        .mem_awaddr_o(mem_awaddr_o), .mem_awlen_o(mem_awlen_o),
        .mem_wvalid_o(mem_wvalid_o), .mem_wready_i(mem_wready_i),
        .mem_wdata_o(mem_wdata_o), .mem_wlast_o(mem_wlast_o),
        .mem_bvalid_i(mem_bvalid_i), .mem_bready_o(mem_bready_o),
        .mem_berror_i(mem_berror_i), .done_o(done_o), .error_o(error_o)
    );

    // Free-running clock, period 10
    always #5 clk_i = ~clk_i;

    // wmode: 0 = ready always high, 1 = wready pattern 1,0,0,..., 2 = random
    typedef struct {
        logic [31:0] addr;
        int          len;
        int          wmode;
        bit          berr;
        int          lo_cycles;
        int          lo_size;
        bit          flush_first;
        logic [7:0]  exp_awlen;
        bit          exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_burst(input vec_t v);
        logic [31:0] words[$];
        int          pulls;
        int          beats;
        int          cyc;
        int          bdelay;
        bit          prev_stall;
        bit          pulled;
        bit          hs;
        logic [31:0] prev_data;

        words.delete();
        for (int i = 0; i < v.len; i++) words.push_back($urandom);
        buffer_valid_i = 1'b1;
        flush_i        = 1'b0;
        if (v.flush_first)       buffer_size_i = 10'(v.len + 2);
        else if (v.lo_cycles > 0) buffer_size_i = 10'(v.lo_size);
        else                     buffer_size_i = 10'(v.len);
        #1;
        check("req_ready_idle", {31'd0, req_ready_o}, 32'd1);

        req_valid_i   = 1'b1;
        req_address_i = v.addr;
        req_length_i  = 5'(v.len);
        tick();
        req_valid_i   = 1'b0;
        req_address_i = $urandom;
        req_length_i  = 5'($urandom_range(1, 16));

        // Start condition true but flushed: no burst may start
        if (v.flush_first) begin
            flush_i = 1'b1;
            #1;
            check("awvalid_flush", {31'd0, mem_awvalid_o}, 32'd0);
            tick();
            flush_i = 1'b0;
        end
        for (int i = 0; i < v.lo_cycles; i++) begin
            buffer_size_i = 10'(v.lo_size);
            req_valid_i   = 1'b1;
            #1;
            check("awvalid_wait_low", {31'd0, mem_awvalid_o}, 32'd0);
            check("req_ready_busy_low", {31'd0, req_ready_o}, 32'd0);
            tick();
            req_valid_i = 1'b0;
        end
        buffer_size_i = 10'(v.len + $urandom_range(0, 3));
        #1;
        check("awvalid_wait", {31'd0, mem_awvalid_o}, 32'd0);
        check("req_ready_busy", {31'd0, req_ready_o}, 32'd0);
        tick();

        // Address phase
        hs = 1'b0;
        for (int i = 0; i < 60 && !hs; i++) begin
            mem_awready_i = (v.wmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            check("awvalid", {31'd0, mem_awvalid_o}, 32'd1);
            check("awaddr", mem_awaddr_o, v.addr);
            check("awlen", {24'd0, mem_awlen_o}, {24'd0, v.exp_awlen});
            check("pull_in_addr", {31'd0, buffer_pull_o}, 32'd0);
            hs = mem_awready_i;
            tick();
        end
        mem_awready_i = 1'b0;
        if (!hs) check("addr_timeout", 32'd1, 32'd0);

        // Data phase: buffer model presents word k after the k-th pull
        pulls = 0; beats = 0; cyc = 0; prev_stall = 1'b0; prev_data = 32'd0;
        while (beats < v.len && cyc < 400) begin
            case (v.wmode)
                0:       mem_wready_i = 1'b1;
                1:       mem_wready_i = (cyc % 3 == 0);
                default: mem_wready_i = 1'($urandom_range(0, 1));
            endcase
            mem_bvalid_i = (v.wmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_berror_i = 1'($urandom_range(0, 1));
            #1;
            check("done_in_data", {31'd0, done_o}, 32'd0);
            if (cyc == 0) check("first_pull", {31'd0, buffer_pull_o}, 32'd1);
            if (prev_stall) begin
                check("wvalid_held", {31'd0, mem_wvalid_o}, 32'd1);
                check("wdata_stable", mem_wdata_o, prev_data);
            end
            if (buffer_pull_o) begin
                check("pull_while_stalled", {31'd0, (mem_wvalid_o && !mem_wready_i)}, 32'd0);
                check("pull_overrun", {31'd0, (pulls < v.len)}, 32'd1);
            end
            if (mem_wvalid_o) begin
                check("wdata", mem_wdata_o, words[beats]);
                check("wlast", {31'd0, mem_wlast_o}, {31'd0, (beats == v.len - 1)});
            end else begin
                check("wlast_idle", {31'd0, mem_wlast_o}, 32'd0);
            end
            prev_stall = mem_wvalid_o && !mem_wready_i;
            prev_data  = mem_wdata_o;
            if (mem_wvalid_o && mem_wready_i) beats++;
            pulled = buffer_pull_o;
            tick();
            if (pulled) begin
                if (pulls < v.len) buffer_data_i = words[pulls];
                pulls++;
            end
            cyc++;
        end
        if (cyc >= 400) check("data_timeout", 32'd1, 32'd0);
        if (v.wmode == 0) check("throughput_cycles", cyc, v.len + 1);

        // Response phase
        mem_wready_i = 1'b0;
        mem_bvalid_i = 1'b0;
        bdelay = (v.wmode == 0) ? 0 : $urandom_range(0, 3);
        for (int i = 0; i < bdelay; i++) begin
            #1;
            check("bready", {31'd0, mem_bready_o}, 32'd1);
            check("done_early", {31'd0, done_o}, 32'd0);
            check("pull_in_resp", {31'd0, buffer_pull_o}, 32'd0);
            tick();
        end
        mem_bvalid_i = 1'b1;
        mem_berror_i = v.berr;
        #1;
        check("pull_total", pulls, v.len);
        check("bready_hs", {31'd0, mem_bready_o}, 32'd1);
        check("done_pulse", {31'd0, done_o}, 32'd1);
        check("error_pulse", {31'd0, error_o}, {31'd0, v.exp_err});
        tick();
        mem_bvalid_i = 1'b0;
        mem_berror_i = 1'b0;
        #1;
        check("done_single", {31'd0, done_o}, 32'd0);
        check("error_single", {31'd0, error_o}, 32'd0);
        check("req_ready_after", {31'd0, req_ready_o}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready_o}, 32'd1);
        check({tag, "_outs"},
              {21'd0, mem_awvalid_o, mem_wvalid_o, mem_wlast_o, buffer_pull_o,
               mem_bready_o, done_o, error_o, 4'd0},
              32'd0);
        check({tag, "_awaddr"}, mem_awaddr_o, 32'd0);
        check({tag, "_awlen"}, {24'd0, mem_awlen_o}, 32'd0);
        check({tag, "_wdata"}, mem_wdata_o, 32'd0);
    endtask

    initial begin
        vec_t r;
        logic [31:0] a;

        vecs[0] = '{32'h0000_1000, 4, 0, 1'b0, 0, 0, 1'b0, 8'd3, 1'b0};
        vecs[1] = '{32'h0000_1000, 4, 0, 1'b0, 3, 2, 1'b0, 8'd3, 1'b0};
        vecs[2] = '{32'h0000_2000, 8, 1, 1'b0, 0, 0, 1'b0, 8'd7, 1'b0};
        vecs[3] = '{32'h0000_3000, 4, 0, 1'b0, 2, 3, 1'b1, 8'd3, 1'b0};
        vecs[4] = '{32'h0000_4000, 4, 2, 1'b1, 0, 0, 1'b0, 8'd3, 1'b1};
        vecs[5] = '{32'hFFFF_FFC0, 16, 2, 1'b0, 1, 15, 1'b0, 8'd15, 1'b0};
        vecs[6] = '{32'h0000_0008, 1, 1, 1'b0, 0, 0, 1'b0, 8'd0, 1'b0};

        rst_n_i = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_address_i = 32'd0;
        req_length_i = 5'd0; buffer_size_i = 10'd0; buffer_valid_i = 1'b0;
        buffer_data_i = 32'd0; mem_awready_i = 1'b0; mem_wready_i = 1'b0;
        mem_bvalid_i = 1'b0; mem_berror_i = 1'b0;
        tick(); tick();
        check_reset_outputs("reset");
        rst_n_i = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_burst(vecs[i]);

        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            a[1:0] = 2'b00;
            r.addr        = a;
            r.len         = $urandom_range(1, 16);
            r.wmode       = $urandom_range(0, 2);
            r.berr        = 1'($urandom_range(0, 1));
            r.lo_cycles   = $urandom_range(0, 2);
            r.lo_size     = $urandom_range(0, r.len - 1);
            r.flush_first = 1'($urandom_range(0, 1));
            r.exp_awlen   = 8'(r.len - 1);
            r.exp_err     = r.berr;
            run_burst(r);
        end

        // Reset in the middle of a 4-beat burst after two accepted beats
        buffer_size_i = 10'd4; buffer_valid_i = 1'b1;
        req_valid_i = 1'b1; req_address_i = 32'h0000_5000; req_length_i = 5'd4;
        tick();
        req_valid_i = 1'b0;
        mem_awready_i = 1'b1;
        tick();
        tick();
        mem_awready_i = 1'b0;
        mem_wready_i  = 1'b1;
        tick();
        tick();
        tick();
        check("mid_burst_wvalid", {31'd0, mem_wvalid_o}, 32'd1);
        rst_n_i = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        mem_wready_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        tick();
        check_reset_outputs("after_release");
        run_burst(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Absolute time limit so a stuck run still reports
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
